// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------
// mem_arb_pkg: shared types and defaults for the memory arbiter.
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int c_MAX_OUT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------
// mem_arbiter_if: icache, dcache and memory-side signals of the arbiter.
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if;
  logic [31:0] i_ic_addr;
  logic        i_ic_ren;
  logic        i_ic_lock;
  logic        o_ic_ready;
  logic [31:0] o_ic_rdata;
  logic        o_ic_valid;

  logic [31:0] i_dc_addr;
  logic        i_dc_ren;
  logic        i_dc_wen;
  logic [31:0] i_dc_wdata;
  logic        i_dc_lock;
  logic        o_dc_ready;
  logic [31:0] o_dc_rdata;
  logic        o_dc_valid;

  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_valid;

  logic        o_err;

  modport slave (
    input  i_ic_addr, i_ic_ren, i_ic_lock,
    output o_ic_ready, o_ic_rdata, o_ic_valid,
    input  i_dc_addr, i_dc_ren, i_dc_wen, i_dc_wdata, i_dc_lock,
    output o_dc_ready, o_dc_rdata, o_dc_valid,
    input  i_mem_ready, i_mem_rdata, i_mem_valid,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
    output o_err
  );

  modport master (
    output i_ic_addr, i_ic_ren, i_ic_lock,
    input  o_ic_ready, o_ic_rdata, o_ic_valid,
    output i_dc_addr, i_dc_ren, i_dc_wen, i_dc_wdata, i_dc_lock,
    input  o_dc_ready, o_dc_rdata, o_dc_valid,
    output i_mem_ready, i_mem_rdata, i_mem_valid,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
    input  o_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_arb_cnt.sv
// ----------------------------------------------------------------------
// mem_arb_cnt: outstanding-read counter with full/zero/spurious flags.
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module mem_arb_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUT = c_MAX_OUT_DEFAULT,
  parameter int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_inc,
  input  logic          i_valid,
  output logic [CW-1:0] o_cnt_next,
  output logic          o_full,
  output logic          o_zero,
  output logic          o_spurious
);

  logic [CW-1:0] r_cnt;
  logic          w_dec;

  assign o_full     = (r_cnt == CW'(MAX_OUT));
  assign o_zero     = (r_cnt == '0);
  // A response with nothing outstanding is not counted down.
  assign w_dec      = i_valid & ~o_zero;
  assign o_spurious = i_valid & o_zero;

  always_comb begin
    o_cnt_next = r_cnt;
    if (i_inc && !w_dec) begin
      o_cnt_next = r_cnt + CW'(1);
    end else if (!i_inc && w_dec) begin
      o_cnt_next = r_cnt - CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_cnt_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------
// mem_arbiter: shares one word memory port between icache and dcache.
// Define MEM_ARB_RR_EN for round-robin ties (else dcache wins). Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int MAX_OUT = c_MAX_OUT_DEFAULT,
  localparam int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus
);

  state_t        r_state;
  state_t        w_state_next;
  owner_t        w_tie_winner;
  logic          r_err;

  logic          w_ic_pend;
  logic          w_dc_pend;
  logic [CW-1:0] w_cnt_next;
  logic          w_full;
  logic          w_zero;
  logic          w_spurious;
  logic          w_inc;
  logic          w_rd_ok;

  logic [31:0]   w_mem_addr;
  logic          w_mem_ren;
  logic          w_mem_wen;
  logic [31:0]   w_mem_wdata;
  logic          w_ic_ready;
  logic          w_dc_ready;
  logic          w_ic_valid;
  logic          w_dc_valid;

  assign w_ic_pend = bus.i_ic_ren | bus.i_ic_lock;
  assign w_dc_pend = bus.i_dc_ren | bus.i_dc_wen | bus.i_dc_lock;
  assign w_inc     = w_mem_ren & bus.i_mem_ready;
  assign w_rd_ok   = bus.i_mem_valid & ~w_zero;

  mem_arb_cnt #(
    .MAX_OUT (MAX_OUT),
    .CW      (CW)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_inc      (w_inc),
    .i_valid    (bus.i_mem_valid),
    .o_cnt_next (w_cnt_next),
    .o_full     (w_full),
    .o_zero     (w_zero),
    .o_spurious (w_spurious)
  );

`ifdef MEM_ARB_RR_EN
  owner_t r_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= OWN_IC;
    end else if (r_state == IDLE && w_state_next == GRANT_I) begin
      r_last <= OWN_IC;
    end else if (r_state == IDLE && w_state_next == GRANT_D) begin
      r_last <= OWN_DC;
    end
  end

  always_comb begin
    w_tie_winner = OWN_DC;
    if (r_last == OWN_DC) begin
      w_tie_winner = OWN_IC;
    end
  end
`else
  assign w_tie_winner = OWN_DC;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= r_err | w_spurious;
    end
  end

  // Owner's request goes straight through; reads are held off while full.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_ren   = 1'b0;
    w_mem_wen   = 1'b0;
    w_mem_wdata = '0;
    w_ic_ready  = 1'b0;
    w_dc_ready  = 1'b0;
    case (r_state)
      GRANT_I: begin
        w_mem_addr = bus.i_ic_addr;
        w_mem_ren  = bus.i_ic_ren & ~w_full;
        w_ic_ready = bus.i_mem_ready & ~(bus.i_ic_ren & w_full);
      end
      GRANT_D: begin
        w_mem_addr  = bus.i_dc_addr;
        w_mem_ren   = bus.i_dc_ren & ~w_full;
        w_mem_wen   = bus.i_dc_wen;
        w_mem_wdata = bus.i_dc_wdata;
        w_dc_ready  = bus.i_mem_ready & ~(bus.i_dc_ren & w_full);
      end
      default: ;
    endcase
  end

  // Ownership is only given up once no reads remain in flight.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_ic_pend && w_dc_pend) begin
          w_state_next = (w_tie_winner == OWN_DC) ? GRANT_D : GRANT_I;
        end else if (w_dc_pend) begin
          w_state_next = GRANT_D;
        end else if (w_ic_pend) begin
          w_state_next = GRANT_I;
        end
      end
      GRANT_I: begin
        if (!bus.i_ic_lock && !bus.i_ic_ren && w_cnt_next == '0) begin
          w_state_next = IDLE;
        end
      end
      GRANT_D: begin
        if (!bus.i_dc_lock && !bus.i_dc_ren && !bus.i_dc_wen && w_cnt_next == '0) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_ic_valid = w_rd_ok & (r_state == GRANT_I);
  assign w_dc_valid = w_rd_ok & (r_state == GRANT_D);

  assign bus.o_mem_addr  = w_mem_addr;
  assign bus.o_mem_ren   = w_mem_ren;
  assign bus.o_mem_wen   = w_mem_wen;
  assign bus.o_mem_wdata = w_mem_wdata;
  assign bus.o_ic_ready  = w_ic_ready;
  assign bus.o_dc_ready  = w_dc_ready;
  assign bus.o_ic_valid  = w_ic_valid;
  assign bus.o_dc_valid  = w_dc_valid;
  assign bus.o_ic_rdata  = w_ic_valid ? bus.i_mem_rdata : 32'd0;
  assign bus.o_dc_rdata  = w_dc_valid ? bus.i_mem_rdata : 32'd0;
  assign bus.o_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------
// tb_mem_arbiter: scoreboard bench with a 2-cycle memory model.
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  logic i_clk = 1'b0;
  logic i_rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_OUT(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { bit dc; logic [31:0] data; } exp_t;

  mreq_t mq[$];
  exp_t  sb[$];
  bit    mem_auto = 1'b1;
  bit    stray = 1'b0;
  int    last_ic_valid = -1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Memory: reads accepted in cycle N return in cycle N+2, in order.
  initial begin
    bus.i_mem_valid = 1'b0;
    bus.i_mem_rdata = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) mq.delete();
      else if (bus.o_mem_ren && bus.i_mem_ready) mq.push_back('{bus.o_mem_addr, cyc + 2});
      step();
      if (stray) begin
        bus.i_mem_valid = 1'b1;
        bus.i_mem_rdata = 32'h5757_5757;
      end else if (mem_auto && mq.size() > 0 && mq[0].due <= cyc) begin
        bus.i_mem_valid = 1'b1;
        bus.i_mem_rdata = mem_data(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus.i_mem_valid = 1'b0;
        bus.i_mem_rdata = '0;
      end
    end
  end

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (bus.o_ic_valid || bus.o_dc_valid) begin
        if (bus.o_ic_valid) last_ic_valid = cyc;
        if (sb.size() == 0) begin
          check("unexpected_valid", {30'd0, bus.o_dc_valid, bus.o_ic_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_side", {30'd0, bus.o_dc_valid, bus.o_ic_valid}, e.dc ? 32'd2 : 32'd1);
          check("resp_data", e.dc ? bus.o_dc_rdata : bus.o_ic_rdata, e.data);
          check("resp_other_rdata", e.dc ? bus.o_ic_rdata : bus.o_dc_rdata, 32'd0);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {25'd0, bus.o_mem_ren, bus.o_mem_wen, bus.o_ic_ready,
          bus.o_dc_ready, bus.o_ic_valid, bus.o_dc_valid, bus.o_err}, 32'd0);
    check({tag, "_mem_bus"}, bus.o_mem_addr | bus.o_mem_wdata, 32'd0);
    check({tag, "_rdata"}, bus.o_ic_rdata | bus.o_dc_rdata, 32'd0);
  endtask

  task automatic issue(input bit dc, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    if (dc) begin
      bus.i_dc_addr  = addr;
      bus.i_dc_wdata = wd;
      bus.i_dc_ren   = !wr;
      bus.i_dc_wen   = wr;
    end else begin
      bus.i_ic_addr = addr;
      bus.i_ic_ren  = 1'b1;
    end
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge i_clk);
      if (dc ? bus.o_dc_ready : bus.o_ic_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
        check("acc_mem_addr", bus.o_mem_addr, addr);
        check("acc_mem_cmd", {30'd0, bus.o_mem_wen, bus.o_mem_ren}, wr ? 32'd2 : 32'd1);
        if (wr) check("acc_mem_wdata", bus.o_mem_wdata, wd);
        else sb.push_back('{dc, mem_data(addr)});
      end else begin
        step();
      end
    end
    check("accepted", {31'd0, ok}, 32'd1);
    step();
    if (dc) begin
      bus.i_dc_ren = 1'b0;
      bus.i_dc_wen = 1'b0;
    end else begin
      bus.i_ic_ren = 1'b0;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge i_clk);
      if (sb.size() == 0 && mq.size() == 0 && !bus.o_ic_ready && !bus.o_dc_ready) ok = 1'b1;
    end
    check("drain_idle", {31'd0, ok}, 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n0, m0;
    logic [31:0] ic_a, dc_a;
    bit exp_w [3];
    bit who, found;
`ifdef MEM_ARB_RR_EN
    exp_w = '{1'b1, 1'b0, 1'b1};
`else
    exp_w = '{1'b1, 1'b1, 1'b1};
`endif
    i_rst = 1'b1;
    bus.i_ic_addr = '0; bus.i_ic_ren = 1'b0; bus.i_ic_lock = 1'b0;
    bus.i_dc_addr = '0; bus.i_dc_ren = 1'b0; bus.i_dc_wen = 1'b0;
    bus.i_dc_wdata = '0; bus.i_dc_lock = 1'b0; bus.i_mem_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    check_zero("reset");
    step();
    i_rst = 1'b0;
    step();

    // icache 4-word line fill under lock
    bus.i_ic_lock = 1'b1; bus.i_ic_ren = 1'b1; bus.i_ic_addr = 32'h100;
    @(negedge i_clk);
    n0 = cyc;
    check("fill_idle_no_fwd", {30'd0, bus.o_mem_ren, bus.o_ic_ready}, 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 1'b0, 32'h100 + 32'(k), 32'd0, acc);
      if (k == 0) check("fill_grant_latency", acc, n0 + 1);
    end
    bus.i_ic_lock = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("fill_hold_then_release", {31'd0, bus.o_ic_ready}, (k < 2) ? 32'd1 : 32'd0);
      step();
    end
    drain();

    // Ties in IDLE
    ic_a = 32'h200; dc_a = 32'h300;
    bus.i_ic_addr = ic_a; bus.i_ic_ren = 1'b1;
    bus.i_dc_addr = dc_a; bus.i_dc_ren = 1'b1;
    for (int r = 0; r < 3; r++) begin
      found = 1'b0; who = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
        @(negedge i_clk);
        if (bus.o_dc_ready && bus.i_dc_ren) begin found = 1'b1; who = 1'b1; end
        else if (bus.o_ic_ready && bus.i_ic_ren) begin found = 1'b1; who = 1'b0; end
        if (!found) step();
      end
      check("tie_grant_seen", {31'd0, found}, 32'd1);
      check("tie_winner_is_dc", {31'd0, who}, {31'd0, exp_w[r]});
      if (who) sb.push_back('{1'b1, mem_data(dc_a)});
      else     sb.push_back('{1'b0, mem_data(ic_a)});
      step();
      if (who) bus.i_dc_ren = 1'b0; else bus.i_ic_ren = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
        @(negedge i_clk);
        found = who ? bus.o_dc_valid : bus.o_ic_valid;
        step();
      end
      check("tie_resp_seen", {31'd0, found}, 32'd1);
      if (r < 2) begin
        if (who) begin dc_a = dc_a + 1; bus.i_dc_addr = dc_a; bus.i_dc_ren = 1'b1; end
        else     begin ic_a = ic_a + 1; bus.i_ic_addr = ic_a; bus.i_ic_ren = 1'b1; end
      end
    end
    issue(1'b0, 1'b0, ic_a, 32'd0, acc);
    drain();

    // Outstanding limit: fifth read stalls until a response returns
    @(negedge i_clk); mem_auto = 1'b0;
    step();
    bus.i_dc_lock = 1'b1;
    for (int k = 0; k < 4; k++) issue(1'b1, 1'b0, 32'h400 + 32'(k), 32'd0, acc);
    bus.i_dc_ren = 1'b1; bus.i_dc_addr = 32'h404;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("full_mem_ren", {31'd0, bus.o_mem_ren}, 32'd0);
      check("full_dc_ready", {31'd0, bus.o_dc_ready}, 32'd0);
      step();
    end
    @(negedge i_clk); m0 = cyc; mem_auto = 1'b1;
    step();
    issue(1'b1, 1'b0, 32'h404, 32'd0, acc);
    check("full_accept_cycle", acc, m0 + 2);
    bus.i_dc_lock = 1'b0;
    drain();

    // dcache write blocked by an icache fill
    bus.i_ic_lock = 1'b1;
    issue(1'b0, 1'b0, 32'h500, 32'd0, acc);
    bus.i_dc_wen = 1'b1; bus.i_dc_addr = 32'h600; bus.i_dc_wdata = 32'hCAFE_F00D;
    issue(1'b0, 1'b0, 32'h501, 32'd0, acc);
    bus.i_ic_lock = 1'b0;
    issue(1'b1, 1'b1, 32'h600, 32'hCAFE_F00D, acc);
    check("wr_after_ic_release", acc, last_ic_valid + 2);
    drain();

    // Stray response with nothing outstanding
    @(negedge i_clk); stray = 1'b1;
    @(negedge i_clk);
    check("stray_no_valid", {30'd0, bus.o_ic_valid, bus.o_dc_valid}, 32'd0);
    check("stray_err_not_yet", {31'd0, bus.o_err}, 32'd0);
    stray = 1'b0;
    @(negedge i_clk);
    check("stray_err_set", {31'd0, bus.o_err}, 32'd1);
    repeat (3) @(negedge i_clk);
    check("err_sticky", {31'd0, bus.o_err}, 32'd1);
    step();

    // Reset with three reads outstanding in GRANT_D
    @(negedge i_clk); mem_auto = 1'b0;
    step();
    bus.i_dc_lock = 1'b1;
    for (int k = 0; k < 3; k++) issue(1'b1, 1'b0, 32'h700 + 32'(k), 32'd0, acc);
    @(negedge i_clk);
    check("rst_pre_grant", {31'd0, bus.o_dc_ready}, 32'd1);
    step();
    i_rst = 1'b1; bus.i_dc_lock = 1'b0; sb.delete();
    @(negedge i_clk);
    check_zero("midrst");
    step();
    i_rst = 1'b0;
    @(negedge i_clk); mem_auto = 1'b1; stray = 1'b1;
    @(negedge i_clk);
    check("postrst_no_valid", {30'd0, bus.o_ic_valid, bus.o_dc_valid}, 32'd0);
    stray = 1'b0;
    @(negedge i_clk);
    check("postrst_cnt_zero_err", {31'd0, bus.o_err}, 32'd1);

    repeat (4) @(negedge i_clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
